// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared definitions for the two-port memory bus arbiter:
//   sequencer state encoding, port identifiers and the default
//   memory address width.
package mem_bus_pkg;

   // Sequencer states: arbitration, first byte, second byte, completion.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BYTE0 = 2'd1,
      BYTE1 = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Port identifiers; also the encoding of the last-grant register.
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   // Default memory byte-address width.
   localparam int DEF_ADDR_W = 16;

endpackage : mem_bus_pkg

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin picker.
//   Ports:
//     i_req0, i_req1 : request lines
//     i_last         : port granted most recently (PORT_CPU / PORT_DMA)
//     o_pick         : one-hot winner, bit 0 = port 0, bit 1 = port 1
//     o_any          : at least one request is present
module rr_arb2
   import mem_bus_pkg::*;
(
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_last,
   output logic [1:0] o_pick,
   output logic       o_any
);

   // Winner selection: a lone requester wins, a tie goes to the port
   // that was not granted last.
   always_comb begin
      o_pick = 2'b00;
      o_any  = i_req0 | i_req1;
      if (i_req0 && i_req1) begin
         if (i_last == PORT_DMA) begin
            o_pick = 2'b01;
         end else begin
            o_pick = 2'b10;
         end
      end else begin
         o_pick = {i_req1, i_req0};
      end
   end

endmodule : rr_arb2

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates the 8-bit memory bus between the CPU path (port 0) and
//   the DMA/debug loader (port 1) and sequences each granted access as
//   one byte cycle or two little-endian byte cycles.
//   Ports:
//     i_clk, i_reset            : clock, synchronous active-high reset
//     i_reqN/i_weN/i_wordN      : request, write enable, 16-bit access
//     i_addrN/i_wdataN          : start address, write data (low byte first)
//     o_gntN/o_doneN/o_rdataN   : ownership, completion pulse, read result
//     o_mem_addr/o_mem_read/o_mem_write/o_mem_wdata/i_mem_rdata : memory side
//   Every output is a flop; the next-output logic is decoded from the
//   next state so the strobes line up with the state they belong to.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_we0,
   input  logic              i_we1,
   input  logic              i_word0,
   input  logic              i_word1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [15:0]       i_wdata0,
   input  logic [15:0]       i_wdata1,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_done0,
   output logic              o_done1,
   output logic [15:0]       o_rdata0,
   output logic [15:0]       o_rdata1,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_read,
   output logic              o_mem_write,
   output logic [7:0]        o_mem_wdata,
   input  logic [7:0]        i_mem_rdata
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic                r_owner;
   logic                r_last;
   logic                r_we;
   logic                r_word;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_wdata;
   logic [7:0]          r_lo;
   logic [15:0]         r_rdata0;
   logic [15:0]         r_rdata1;
   logic                r_gnt0;
   logic                r_gnt1;
   logic                r_done0;
   logic                r_done1;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_read;
   logic                r_mem_write;
   logic [7:0]          r_mem_wdata;

   state_t              w_state_next;
   logic                w_owner_next;
   logic                w_we_next;
   logic                w_word_next;
   logic [ADDR_W-1:0]   w_addr_next;
   logic [15:0]         w_wdata_next;
   logic                w_grant;
   logic [1:0]          w_pick;
   logic                w_any;
   logic                w_gnt0_next;
   logic                w_gnt1_next;
   logic                w_done0_next;
   logic                w_done1_next;
   logic [ADDR_W-1:0]   w_mem_addr_next;
   logic                w_mem_read_next;
   logic                w_mem_write_next;
   logic [7:0]          w_mem_wdata_next;

   rr_arb2 u_rr_arb2 (
      .i_req0 (i_req0),
      .i_req1 (i_req1),
      .i_last (r_last),
      .o_pick (w_pick),
      .o_any  (w_any)
   );

   // Next-state logic and transaction latching at grant time.
   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_we_next    = r_we;
      w_word_next  = r_word;
      w_addr_next  = r_addr;
      w_wdata_next = r_wdata;
      w_grant      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_next = BYTE0;
               w_grant      = 1'b1;
               if (w_pick == 2'b10) begin
                  w_owner_next = PORT_DMA;
                  w_we_next    = i_we1;
                  w_word_next  = i_word1;
                  w_addr_next  = i_addr1;
                  w_wdata_next = i_wdata1;
               end else begin
                  w_owner_next = PORT_CPU;
                  w_we_next    = i_we0;
                  w_word_next  = i_word0;
                  w_addr_next  = i_addr0;
                  w_wdata_next = i_wdata0;
               end
            end else begin
               w_state_next = IDLE;
            end
         end
         BYTE0: begin
            if (r_word) begin
               w_state_next = BYTE1;
            end else begin
               w_state_next = DONE;
            end
         end
         BYTE1:   w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Output values for the coming cycle, decoded from the next state.
   always_comb begin
      w_gnt0_next      = 1'b0;
      w_gnt1_next      = 1'b0;
      w_done0_next     = 1'b0;
      w_done1_next     = 1'b0;
      w_mem_addr_next  = {ADDR_W{1'b0}};
      w_mem_read_next  = 1'b0;
      w_mem_write_next = 1'b0;
      w_mem_wdata_next = 8'h00;
      if (w_state_next != IDLE) begin
         w_gnt0_next = (w_owner_next == PORT_CPU);
         w_gnt1_next = (w_owner_next == PORT_DMA);
      end else begin
         w_gnt0_next = 1'b0;
         w_gnt1_next = 1'b0;
      end
      case (w_state_next)
         BYTE0: begin
            w_mem_addr_next  = w_addr_next;
            w_mem_read_next  = ~w_we_next;
            w_mem_write_next = w_we_next;
            w_mem_wdata_next = w_we_next ? w_wdata_next[7:0] : 8'h00;
         end
         BYTE1: begin
            // Address wraps naturally at 2^ADDR_W.
            w_mem_addr_next  = w_addr_next + ADDR_ONE;
            w_mem_read_next  = ~w_we_next;
            w_mem_write_next = w_we_next;
            w_mem_wdata_next = w_we_next ? w_wdata_next[15:8] : 8'h00;
         end
         DONE: begin
            w_done0_next = (w_owner_next == PORT_CPU);
            w_done1_next = (w_owner_next == PORT_DMA);
         end
         default: begin
            w_mem_addr_next = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State, latched transaction, read assembly and output registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_owner     <= PORT_CPU;
         r_last      <= PORT_DMA;
         r_we        <= 1'b0;
         r_word      <= 1'b0;
         r_addr      <= {ADDR_W{1'b0}};
         r_wdata     <= 16'h0000;
         r_lo        <= 8'h00;
         r_rdata0    <= 16'h0000;
         r_rdata1    <= 16'h0000;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_wdata <= 8'h00;
      end else begin
         r_state     <= w_state_next;
         r_owner     <= w_owner_next;
         r_we        <= w_we_next;
         r_word      <= w_word_next;
         r_addr      <= w_addr_next;
         r_wdata     <= w_wdata_next;
         r_gnt0      <= w_gnt0_next;
         r_gnt1      <= w_gnt1_next;
         r_done0     <= w_done0_next;
         r_done1     <= w_done1_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_read  <= w_mem_read_next;
         r_mem_write <= w_mem_write_next;
         r_mem_wdata <= w_mem_wdata_next;
         if (w_grant) begin
            r_last <= w_owner_next;
         end else begin
            r_last <= r_last;
         end
         // Read data lands in the owner's register on entry to DONE,
         // so it is already valid while done pulses.
         if (r_state == BYTE0 && !r_we) begin
            r_lo <= i_mem_rdata;
            if (!r_word) begin
               if (r_owner == PORT_DMA) begin
                  r_rdata1 <= {8'h00, i_mem_rdata};
               end else begin
                  r_rdata0 <= {8'h00, i_mem_rdata};
               end
            end
         end else if (r_state == BYTE1 && !r_we) begin
            if (r_owner == PORT_DMA) begin
               r_rdata1 <= {i_mem_rdata, r_lo};
            end else begin
               r_rdata0 <= {i_mem_rdata, r_lo};
            end
         end
      end
   end

   assign o_gnt0      = r_gnt0;
   assign o_gnt1      = r_gnt1;
   assign o_done0     = r_done0;
   assign o_done1     = r_done1;
   assign o_rdata0    = r_rdata0;
   assign o_rdata1    = r_rdata1;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_read  = r_mem_read;
   assign o_mem_write = r_mem_write;
   assign o_mem_wdata = r_mem_wdata;

endmodule : mem_bus_arbiter

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and access sequencer for the 8-bit system memory bus. It shares memory between the CPU fetch/execute path (port 0) and a DMA/debug loader (port 1). Each granted transaction is a byte access or a little-endian 16-bit word access, which it splits into two byte cycles. It sits between the control/datapath and the memory, and owns `mem_read`/`mem_write`.

## Interface
- `ADDR_W`, default 16: memory address width.
- `clk`  in  1: system clock; everything updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req0`, `req1`  in  1: transaction request; held high until the matching `done`.
- `we0`, `we1`  in  1: 1 = write, 0 = read; sampled at grant.
- `word0`, `word1`  in  1: 1 = 16-bit access (two bytes), 0 = single byte; sampled at grant.
- `addr0`, `addr1`  in  ADDR_W: start byte address; sampled at grant.
- `wdata0`, `wdata1`  in  16: write data; low byte is written first; byte access uses [7:0]; sampled at grant.
- `gnt0`, `gnt1`  out  1: high while the port owns the bus (BYTE0, BYTE1 and DONE).
- `done0`, `done1`  out  1: one-cycle completion pulse.
- `rdata0`, `rdata1`  out  16: read result; byte read zero-extends; held until that port's next `done`.
- `mem_addr`  out  ADDR_W: memory byte address.
- `mem_read`, `mem_write`  out  1: memory strobes; never high together.
- `mem_wdata`  out  8: memory write byte.
- `mem_rdata`  in  8: memory read byte; combinational, valid in the same cycle as `mem_read`.

## Operation
- FSM states: IDLE, BYTE0, BYTE1, DONE.
- IDLE:
  - If any `req` is high, pick an owner, latch its `we`, `word`, `addr` and `wdata`, and go to BYTE0.
  - Otherwise stay in IDLE.
- Arbitration (IDLE only):
  - Single requester wins.
  - If both request, the port not granted last wins (round-robin).
  - The last-grant register resets to port 1, so port 0 wins the first tie.
- BYTE0:
  - `mem_addr` = latched addr.
  - Read: `mem_read` = 1 and `mem_rdata` is captured into a low-byte staging register.
  - Write: `mem_write` = 1 and `mem_wdata` = wdata[7:0].
  - Next state is BYTE1 if word, else DONE.
- BYTE1:
  - `mem_addr` = latched addr + 1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - Read: capture `mem_rdata` as the high byte.
  - Write: `mem_wdata` = wdata[15:8].
  - Next state is DONE.
- DONE:
  - The owner's `done` is asserted and its `rdata` is updated (reads only; writes leave `rdata` unchanged).
  - `req` inputs are ignored.
  - Next state is IDLE.
- `gnt`/`done` of the non-owner stay 0 throughout.
- A requester that keeps `req` high through DONE is starting a new transaction. Its `addr`/`we`/`word`/`wdata` must be valid by the IDLE cycle, and it competes in arbitration normally.
- Dropping `req` mid-transaction does not abort; the transaction completes and `done` still pulses.
- Reset mid-transaction:
  - FSM returns to IDLE and all strobes, `gnt` and `done` are 0 from the next cycle.
  - The transaction is abandoned with no `done`.
  - A byte already written in BYTE0 stays in memory.

## Timing
- Reset values:
  - state = IDLE.
  - `gnt0`/`gnt1`/`done0`/`done1` = 0.
  - `mem_read`/`mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `rdata0`/`rdata1` = 0x0000.
  - last-grant = port 1.
- All outputs are registered or decoded from registered state only; there is no combinational path from `req` to any output.
- `req` sampled at edge E means BYTE0 runs in cycle E+1.
- Byte access: `done` in cycle E+2, 3 cycles from request to the next possible IDLE.
- Word access: `done` in cycle E+3.
- Minimum occupancy is 3 cycles for a byte access and 4 for a word access, IDLE included.
- Sustained alternating two-port word traffic runs one word per 4 cycles.

## Structure
- Package `mem_bus_pkg`:
  - state enum (IDLE, BYTE0, BYTE1, DONE).
  - port id constants `PORT_CPU` = 0, `PORT_DMA` = 1.
  - `ADDR_W` default.
- Sub-module `rr_arb2`:
  - Combinational 2-way round-robin picker.
  - Inputs: `req0`, `req1`, `last`.
  - Outputs: one-hot `pick`, `any`.
  - The last-grant register stays in `mem_bus_arbiter`.

## Test plan
- Reset, then `req0` byte read of addr 0x0010 with memory[0x0010] = 0xA5:
  - `mem_read` high with `mem_addr` = 0x0010 one cycle after the request.
  - `done0` two cycles after the request, `rdata0` = 0x00A5, `gnt1` stays 0.
- `req1` word write of 0x1234 to 0x0100:
  - Cycles show `mem_write`/0x0100/0x34 then 0x0101/0x12.
  - `done1` on the third cycle and memory holds 34 12.
- `req0` and `req1` raised in the same cycle after reset, each requesting a word read:
  - Port 0 is granted first.
  - Port 1 is granted in the IDLE right after port 0's DONE.
  - Next simultaneous tie goes to port 0 again.
- Word read at 0xFFFF: second byte cycle drives `mem_addr` = 0x0000, and `rdata` = {mem[0x0000], mem[0xFFFF]}.
- `reset` asserted during BYTE1 of a word write:
  - Next cycle is IDLE with all strobes 0, no `done`.
  - mem[addr] holds the new low byte and mem[addr+1] is unchanged.
- Port 0 holds `req0` high continuously while `req1` also requests: grants alternate 0, 1, 0, 1 and neither port starves.
